// File: rtl/mem_read_arbiter_pkg.sv
// mem_read_arbiter_pkg
//   Shared types and constants for the read arbiter (and its sibling write arbiter).
//   - arb_state_t  : arbiter FSM states
//   - ARB_ID_WIDTH : width of the external AXI ID field (carries the master index)
//   - beat_cnt_inc : saturating increment for the 4-bit beat counter
package mem_read_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } arb_state_t;

    localparam int ARB_ID_WIDTH  = 4;
    localparam int ARB_LEN_WIDTH = 4;
    localparam int ARB_CNT_WIDTH = 32;

    // RLAST, not ARLEN, ends a burst, so a long burst just parks the counter at 15.
    function automatic logic [ARB_LEN_WIDTH-1:0] beat_cnt_inc(input logic [ARB_LEN_WIDTH-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/mem_read_arbiter_rr_picker.sv
// mem_read_arbiter_rr_picker
//   Combinational requester picker, shared with the write arbiter.
//   With rr_en_i=1 it picks the first requester at or after ptr_i (wrapping N-1 -> 0);
//   with rr_en_i=0 it is plain fixed priority, lowest index wins.
// Ports
//   req_i   [N]   request vector
//   ptr_i   [IW]  round-robin start index (must be < N)
//   rr_en_i       1 = round-robin, 0 = fixed priority
//   grant_o [N]   one-hot winner (0 when no request)
//   idx_o   [IW]  winner index
//   any_o         at least one request present
module mem_read_arbiter_rr_picker #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          rr_en_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        int base;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        base    = rr_en_i ? int'(ptr_i) : 0;
        // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
        for (int k = N - 1; k >= 0; k--) begin
            int c;
            c = (base + k) % N;
            if (req_i[c]) begin
                grant_o    = '0;
                grant_o[c] = 1'b1;
                idx_o      = IW'(c);
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter
//   N-master read arbiter onto a single external AR/R channel pair, one burst in flight.
//   IDLE picks a winner (registered, 1-cycle grant latency), ADDR presents AR until ARREADY,
//   DATA forwards R beats combinationally to the winner until a matching RLAST.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   m_arvalid/m_arready      per-master request / one-cycle one-hot accept
//   m_araddr, m_arlen        per-master address and length-1, master i at [i*W +: W]
//   m_rvalid, m_rlast,
//   m_rdata                  beat return (m_rvalid only on the winner's bit)
//   ARVALID/ARREADY, ARID,
//   ARLEN, ARADDR            external address channel, ARID = winner index
//   RVALID, RLAST, RID,
//   RDATA, RREADY            external data channel, RREADY high only in DATA
//   rid_err                  sticky: a beat arrived with RID != ARID
//   grant_cnt                per-master completed-burst counters (32 bits each)
// Config macro
//   ARB_GRANT_CNT_EN         when defined, grant_cnt counts; otherwise it is tied to 0
module mem_read_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int READ_MASTERS = 3,
    parameter int ADDR_WIDTH   = 26,
    parameter int DATA_WIDTH   = 32,
    parameter int RR_EN        = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [READ_MASTERS-1:0]              m_arvalid,
    output logic [READ_MASTERS-1:0]              m_arready,
    input  logic [READ_MASTERS*ADDR_WIDTH-1:0]   m_araddr,
    input  logic [READ_MASTERS*ARB_LEN_WIDTH-1:0] m_arlen,
    output logic [READ_MASTERS-1:0]              m_rvalid,
    output logic                                 m_rlast,
    output logic [DATA_WIDTH-1:0]                m_rdata,
    output logic                                 ARVALID,
    input  logic                                 ARREADY,
    output logic [ARB_ID_WIDTH-1:0]              ARID,
    output logic [ARB_LEN_WIDTH-1:0]             ARLEN,
    output logic [ADDR_WIDTH-1:0]                ARADDR,
    input  logic                                 RVALID,
    input  logic                                 RLAST,
    input  logic [ARB_ID_WIDTH-1:0]              RID,
    input  logic [DATA_WIDTH-1:0]                RDATA,
    output logic                                 RREADY,
    output logic                                 rid_err,
    output logic [READ_MASTERS*ARB_CNT_WIDTH-1:0] grant_cnt
);

    localparam int IW = $clog2(READ_MASTERS);

    arb_state_t                state_q, state_d;
    logic [IW-1:0]             idx_q;
    logic [READ_MASTERS-1:0]   win_oh_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [ARB_LEN_WIDTH-1:0]  len_q;
    logic [IW-1:0]             ptr_q;
    logic [ARB_LEN_WIDTH-1:0]  beat_q;
    logic                      rid_err_q;

    logic [READ_MASTERS-1:0]   pick_oh;
    logic [IW-1:0]             pick_idx;
    logic                      pick_any;

    mem_read_arbiter_rr_picker #(
        .N  (READ_MASTERS),
        .IW (IW)
    ) u_picker (
        .req_i   (m_arvalid),
        .ptr_i   (ptr_q),
        .rr_en_i (RR_EN != 0),
        .grant_o (pick_oh),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign ARID    = ARB_ID_WIDTH'(idx_q);
    assign ARLEN   = len_q;
    assign ARADDR  = addr_q;
    assign rid_err = rid_err_q;

    // A beat carrying someone else's ID is not ours: it is neither forwarded nor allowed to end the burst.
    logic beat_ok, beat_bad, burst_done;
    assign beat_ok    = (state_q == S_DATA) && RVALID && (RID == ARID);
    assign beat_bad   = (state_q == S_DATA) && RVALID && (RID != ARID);
    assign burst_done = beat_ok && RLAST;

    always_comb begin
        state_d   = state_q;
        ARVALID   = 1'b0;
        RREADY    = 1'b0;
        m_arready = '0;
        m_rvalid  = '0;
        m_rlast   = 1'b0;
        m_rdata   = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_any) state_d = S_ADDR;
            end
            S_ADDR: begin
                ARVALID = 1'b1;
                if (ARREADY) begin
                    m_arready = win_oh_q;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                RREADY = 1'b1;
                if (beat_ok) begin
                    m_rvalid = win_oh_q;
                    m_rdata  = RDATA;
                    m_rlast  = RLAST;
                    if (RLAST) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            win_oh_q  <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            ptr_q     <= '0;
            beat_q    <= '0;
            rid_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Request is captured here; later changes to the master's inputs no longer matter.
            if (state_q == S_IDLE && pick_any) begin
                idx_q    <= pick_idx;
                win_oh_q <= pick_oh;
                addr_q   <= m_araddr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                len_q    <= m_arlen[pick_idx*ARB_LEN_WIDTH +: ARB_LEN_WIDTH];
                beat_q   <= '0;
            end
            if (beat_ok) beat_q <= beat_cnt_inc(beat_q);
            if (burst_done) ptr_q <= (idx_q == IW'(READ_MASTERS - 1)) ? '0 : idx_q + 1'b1;
            if (beat_bad) rid_err_q <= 1'b1;
        end
    end

`ifdef ARB_GRANT_CNT_EN
    logic [READ_MASTERS-1:0][ARB_CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (burst_done) begin
            for (int i = 0; i < READ_MASTERS; i++)
                if (win_oh_q[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
        end
    end

    assign grant_cnt = cnt_q;
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_read_arbiter.sv
`timescale 1ns/1ps
module tb_mem_read_arbiter;
    localparam int N  = 3;
    localparam int AW = 26;
    localparam int DW = 32;
`ifdef ARB_GRANT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    m_arvalid;
    logic [N*AW-1:0] m_araddr;
    logic [N*4-1:0]  m_arlen;
    logic            ARREADY, RVALID, RLAST;
    logic [3:0]      RID;
    logic [DW-1:0]   RDATA;

    // Outputs of the round-robin (_r) and fixed-priority (_f) instances.
    logic [N-1:0]    m_arready_r, m_rvalid_r, m_arready_f, m_rvalid_f;
    logic            m_rlast_r, m_rlast_f, arvalid_r, arvalid_f, rready_r, rready_f, riderr_r, riderr_f;
    logic [DW-1:0]   m_rdata_r, m_rdata_f;
    logic [3:0]      arid_r, arid_f, arlen_r, arlen_f;
    logic [AW-1:0]   araddr_r, araddr_f;
    logic [N*32-1:0] gcnt_r, gcnt_f;

    mem_read_arbiter #(.READ_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_EN(1)) dut (
        .clk(clk), .rst(rst), .m_arvalid(m_arvalid), .m_arready(m_arready_r),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_rvalid(m_rvalid_r), .m_rlast(m_rlast_r),
        .m_rdata(m_rdata_r), .ARVALID(arvalid_r), .ARREADY(ARREADY), .ARID(arid_r),
        .ARLEN(arlen_r), .ARADDR(araddr_r), .RVALID(RVALID), .RLAST(RLAST), .RID(RID),
        .RDATA(RDATA), .RREADY(rready_r), .rid_err(riderr_r), .grant_cnt(gcnt_r));

    mem_read_arbiter #(.READ_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst), .m_arvalid(m_arvalid), .m_arready(m_arready_f),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_rvalid(m_rvalid_f), .m_rlast(m_rlast_f),
        .m_rdata(m_rdata_f), .ARVALID(arvalid_f), .ARREADY(ARREADY), .ARID(arid_f),
        .ARLEN(arlen_f), .ARADDR(araddr_f), .RVALID(RVALID), .RLAST(RLAST), .RID(RID),
        .RDATA(RDATA), .RREADY(rready_f), .rid_err(riderr_f), .grant_cnt(gcnt_f));

    // Observed view: whichever instance the current step is exercising.
    bit fp_sel = 1'b0;
    logic [N-1:0]    o_arready, o_rvalid;
    logic            o_rlast, o_arvalid, o_rready, o_riderr;
    logic [DW-1:0]   o_rdata;
    logic [3:0]      o_arid, o_arlen;
    logic [AW-1:0]   o_araddr;
    logic [N*32-1:0] o_gcnt;
    assign o_arready = fp_sel ? m_arready_f : m_arready_r;
    assign o_rvalid  = fp_sel ? m_rvalid_f  : m_rvalid_r;
    assign o_rlast   = fp_sel ? m_rlast_f   : m_rlast_r;
    assign o_rdata   = fp_sel ? m_rdata_f   : m_rdata_r;
    assign o_arvalid = fp_sel ? arvalid_f   : arvalid_r;
    assign o_arid    = fp_sel ? arid_f      : arid_r;
    assign o_arlen   = fp_sel ? arlen_f     : arlen_r;
    assign o_araddr  = fp_sel ? araddr_f    : araddr_r;
    assign o_rready  = fp_sel ? rready_f    : rready_r;
    assign o_riderr  = fp_sel ? riderr_f    : riderr_r;
    assign o_gcnt    = fp_sel ? gcnt_f      : gcnt_r;

    typedef struct {
        logic [N-1:0]  rv;
        logic [DW-1:0] d;
        logic          last;
    } beat_t;

    int    vecs = 0;
    int    errs = 0;
    int    exp_id_q[$];
    beat_t beat_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int m, input logic [AW-1:0] a, input logic [3:0] l);
        m_araddr[m*AW +: AW] = a;
        m_arlen[m*4 +: 4]    = l;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; m_arvalid = '0; ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Hold ARREADY high until the observed instance presents AR, check the request, then release.
    task automatic do_addr(input int exp_id, input logic [3:0] exp_len, input logic [AW-1:0] exp_addr,
                           input bit drop);
        bit seen = 1'b0;
        int id;
        exp_id_q.push_back(exp_id);
        ARREADY = 1'b1;
        for (int n = 0; n < 16 && !seen; n++) begin
            @(negedge clk); #4;
            if (o_arvalid) begin
                seen = 1'b1;
                id = exp_id_q.pop_front();
                chk("arid", o_arid, id);
                chk("arlen", o_arlen, exp_len);
                chk("araddr", o_araddr, exp_addr);
                chk("m_arready", o_arready, N'(1) << id);
            end
        end
        if (!seen) begin
            void'(exp_id_q.pop_front());
            chk("ar_timeout", o_arvalid, 1);
        end
        @(negedge clk);
        ARREADY = 1'b0;
        if (drop) m_arvalid = '0;
    endtask

    task automatic do_beat(input int id, input int rid, input logic [DW-1:0] d, input bit last);
        beat_t e;
        @(negedge clk);
        RVALID = 1'b1; RID = 4'(rid); RDATA = d; RLAST = last;
        e.rv   = (rid == id) ? (N'(1) << id) : '0;
        e.d    = (rid == id) ? d : '0;
        e.last = (rid == id) && last;
        beat_q.push_back(e);
        #4;
        e = beat_q.pop_front();
        chk("rready", o_rready, 1);
        chk("m_rvalid", o_rvalid, e.rv);
        chk("m_rdata", o_rdata, e.d);
        chk("m_rlast", o_rlast, e.last);
    endtask

    task automatic end_beats();
        @(negedge clk);
        RVALID = 1'b0; RLAST = 1'b0;
    endtask

    initial begin
        rst = 1'b1; m_arvalid = 3'b111; m_araddr = '0; m_arlen = '0;
        ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RID = '0; RDATA = '0;

        // Reset held with all masters requesting.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #4;
            chk("rst_arvalid", {arvalid_r, arvalid_f}, 0);
            chk("rst_arready", {m_arready_r, m_arready_f}, 0);
            chk("rst_rready", {rready_r, rready_f}, 0);
            chk("rst_riderr", riderr_r, 0);
            chk("rst_gcnt", gcnt_r, 0);
        end

        // Single master 1, 4-beat burst.
        @(negedge clk);
        m_arvalid = 3'b010; set_req(1, 26'h0000100, 4'd3);
        rst = 1'b0;
        do_addr(1, 4'd3, 26'h0000100, 1'b1);
        for (int b = 0; b < 4; b++) do_beat(1, 1, 32'hA0 + b, b == 3);
        end_beats();
        #4;
        chk("t2_idle_rready", o_rready, 0);
        chk("t2_idle_arvalid", o_arvalid, 0);
        chk("t2_riderr", o_riderr, 0);

        // Round-robin, all masters requesting continuously, single-beat bursts.
        do_reset();
        for (int m = 0; m < N; m++) set_req(m, AW'(m * 32'h1000 + 32'h10), 4'd0);
        m_arvalid = 3'b111;
        for (int b = 0; b < 6; b++) begin
            do_addr(b % N, 4'd0, AW'((b % N) * 32'h1000 + 32'h10), 1'b0);
            do_beat(b % N, b % N, 32'hB0 + b, 1'b1);
            end_beats();
        end
        #4;
        chk("t3_gcnt", o_gcnt, CNT_EN ? {32'd2, 32'd2, 32'd2} : 96'd0);

        // Fixed priority: master 0 wins every time.
        do_reset();
        fp_sel = 1'b1;
        m_arvalid = 3'b111;
        for (int b = 0; b < 3; b++) begin
            do_addr(0, 4'd0, 26'h10, 1'b0);
            do_beat(0, 0, 32'hF0 + b, 1'b1);
            end_beats();
        end
        #4;
        chk("t4_gcnt", o_gcnt, CNT_EN ? {32'd0, 32'd0, 32'd3} : 96'd0);

        // RID mismatch: dropped beat, sticky error, matching beat still forwarded.
        do_reset();
        fp_sel = 1'b0;
        m_arvalid = 3'b001; set_req(0, 26'h40, 4'd1);
        do_addr(0, 4'd1, 26'h40, 1'b1);
        do_beat(0, 2, 32'hC0, 1'b0);
        do_beat(0, 0, 32'hC1, 1'b1);
        chk("t5_riderr_set", o_riderr, 1);
        end_beats();
        #4;
        chk("t5_riderr_sticky", o_riderr, 1);
        chk("t5_idle_rready", o_rready, 0);

        // Reset mid-burst after beat 2 of 4.
        m_arvalid = 3'b100; set_req(2, 26'h2000, 4'd3);
        do_addr(2, 4'd3, 26'h2000, 1'b1);
        do_beat(2, 2, 32'hD0, 1'b0);
        do_beat(2, 2, 32'hD1, 1'b0);
        chk("t6_gcnt_pre", o_gcnt, CNT_EN ? {32'd0, 32'd0, 32'd1} : 96'd0);
        @(negedge clk);
        RDATA = 32'hD2; RLAST = 1'b0; rst = 1'b1;
        #1;
        chk("t6_rst_rvalid", o_rvalid, 0);
        chk("t6_rst_rdata", o_rdata, 0);
        chk("t6_rst_rready", o_rready, 0);
        chk("t6_rst_riderr", o_riderr, 0);
        chk("t6_rst_gcnt", o_gcnt, 0);
        @(negedge clk);
        rst = 1'b0; RDATA = 32'hD3; RLAST = 1'b1;
        #4;
        chk("t6_post_rvalid", o_rvalid, 0);
        chk("t6_post_rready", o_rready, 0);
        chk("t6_post_arvalid", o_arvalid, 0);
        end_beats();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
